// File: rtl/seq_add32.sv
// Multi-cycle 32-bit adder: a + b + c_in computed one CHUNK-bit slice per clock,
// with the inter-slice carry held in a register. Start/busy/done handshake.
module seq_add32 #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        c_out,
  output logic        overflow
);

  localparam int N  = 32 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_sum;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;
  logic            r_c_out;
  logic            r_overflow;

  logic [4:0]       w_lsb;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_slice;
  logic             w_last;

  assign w_lsb   = 5'(r_cnt * CHUNK);
  assign w_a_sl  = r_a[w_lsb +: CHUNK];
  assign w_b_sl  = r_b[w_lsb +: CHUNK];
  assign w_slice = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(N - 1));

  // Handshake FSM and slice datapath; all outputs come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_sum      <= 32'd0;
      r_cnt      <= {CW{1'b0}};
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= 32'd0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[w_lsb +: CHUNK] <= w_slice[CHUNK-1:0];
          r_carry               <= w_slice[CHUNK];
          r_cnt                 <= r_cnt + CW'(1);
          // The last slice holds bit 31, so its top bit is the final sign bit.
          if (w_last) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_c_out    <= w_slice[CHUNK];
            r_overflow <= (r_a[31] == r_b[31]) && (w_slice[CHUNK-1] != r_a[31]);
          end else begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;

endmodule
